// File: rtl/ser_adder.sv
// Bit-serial LSB-first adder with a WIDTH-bit result shift register and serial unload.
// Optional macro SERADD_PASSTHRU_EN: in add mode S shows the current combinational sum bit.
module ser_adder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             A,
    input  logic             B,
    output logic             S,
    output logic             cout,
    output logic [WIDTH-1:0] sum_par,
    output logic             done
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic             c;
    logic [WIDTH-1:0] r;
    logic [CW-1:0]    cnt;
    logic             sum_bit;
    logic             carry_next;
    logic             last_bit;

    assign sum_bit    = A ^ B ^ c;
    assign carry_next = (A & B) | (A & c) | (B & c);
    assign last_bit   = (cnt == LAST);

    // Unload (or a mid-word load) discards any partial carry/count but keeps r.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c    <= 1'b0;
            r    <= '0;
            cnt  <= '0;
            cout <= 1'b0;
            done <= 1'b0;
        end else if (load) begin
            r    <= {1'b0, r[WIDTH-1:1]};
            c    <= 1'b0;
            cnt  <= '0;
            done <= 1'b0;
        end else begin
            r <= {sum_bit, r[WIDTH-1:1]};
            if (last_bit) begin
                cnt  <= '0;
                cout <= carry_next;
                c    <= 1'b0;
                done <= 1'b1;
            end else begin
                cnt  <= cnt + CW'(1);
                c    <= carry_next;
                done <= 1'b0;
            end
        end
    end

    assign sum_par = r;

`ifdef SERADD_PASSTHRU_EN
    assign S = load ? r[0] : sum_bit;
`else
    assign S = r[0];
`endif

endmodule

// File: tb/tb_ser_adder.sv
// Self-checking bench for ser_adder: directed scenarios then random traffic,
// compared against a word-level arithmetic model of the serial adder.
module tb_ser_adder;

    localparam int W    = 4;
    localparam int MASK = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         load;
    logic         A;
    logic         B;
    logic         S;
    logic         cout;
    logic [W-1:0] sum_par;
    logic         done;

    int numChecks = 0;
    int numErrors = 0;

    // Word-level model: operands accumulated as integers, result register derived
    // from the register contents at word start plus the low k bits of the partial sum.
    int rStart, rModel, aW, bW, k, coutM, doneM;

    ser_adder #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .A      (A),
        .B      (B),
        .S      (S),
        .cout   (cout),
        .sum_par(sum_par),
        .done   (done)
    );

    always #5 clk = ~clk;

    function automatic int carryModel();
        if (k == 0) return 0;
        return ((aW + bW) >> k) & 1;
    endfunction

    task automatic modelReset();
        rStart = 0; rModel = 0; aW = 0; bW = 0; k = 0; coutM = 0; doneM = 0;
    endtask

    task automatic modelStep(input int l, input int a, input int b);
        int sum;
        if (l != 0) begin
            rModel = rModel >> 1;
            rStart = rModel;
            aW = 0; bW = 0; k = 0;
            doneM = 0;
        end else begin
            aW = aW | (a << k);
            bW = bW | (b << k);
            k  = k + 1;
            sum = aW + bW;
            if (k == W) begin
                rModel = sum & MASK;
                coutM  = (sum >> W) & 1;
                doneM  = 1;
                rStart = rModel;
                aW = 0; bW = 0; k = 0;
            end else begin
                rModel = (rStart >> k) | ((sum & ((1 << k) - 1)) << (W - k));
                doneM  = 0;
            end
        end
    endtask

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        numChecks++;
        assert (obs === exp) else begin
            numErrors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        int sExp;
`ifdef SERADD_PASSTHRU_EN
        sExp = load ? (rModel & 1) : ((int'(A) ^ int'(B) ^ carryModel()) & 1);
`else
        sExp = rModel & 1;
`endif
        checkVal({tag, ".S"},       32'(S),       32'(sExp));
        checkVal({tag, ".sum_par"}, 32'(sum_par), 32'(rModel & MASK));
        checkVal({tag, ".cout"},    32'(cout),    32'(coutM));
        checkVal({tag, ".done"},    32'(done),    32'(doneM));
    endtask

    task automatic applyStimulus(input string tag, input int l, input int a, input int b);
        load = l[0]; A = a[0]; B = b[0];
        @(posedge clk);
        #1;
        modelStep(l & 1, a & 1, b & 1);
        checkOutput(tag);
    endtask

    task automatic addWord(input string tag, input int a, input int b);
        for (int i = 0; i < W; i++) applyStimulus(tag, 0, (a >> i) & 1, (b >> i) & 1);
    endtask

    // Raise reset between edges, check it takes effect immediately and holds over an edge.
    task automatic pulseReset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        modelReset();
        checkOutput({tag, ".async"});
        @(posedge clk);
        #1;
        checkOutput({tag, ".hold"});
        rst = 1'b0;
    endtask

    initial begin
        int sel;
        rst = 1'b1; load = 1'b0; A = 1'b0; B = 1'b0;
        modelReset();
        #1;
        checkOutput("por");
        @(posedge clk);
        #1;
        checkOutput("por_hold");
        rst = 1'b0;

        // 10 + 7 = 17 -> 0001 with carry out
        addWord("add10p7", 10, 7);
        checkVal("add10p7.sum_const",  32'(sum_par), 32'h1);
        checkVal("add10p7.cout_const", 32'(cout),    32'h1);
        checkVal("add10p7.done_const", 32'(done),    32'h1);

        // Unload: S before shifts is bit 0, then zeros fill in
        checkVal("unload.first_S", 32'(S), 32'h1);
        for (int i = 0; i < W; i++) applyStimulus("unload", 1, 0, 0);
        checkVal("unload.sum_const",  32'(sum_par), 32'h0);
        checkVal("unload.cout_const", 32'(cout),    32'h1);

        // Back-to-back words without idle cycle
        addWord("b2b_3p4", 3, 4);
        checkVal("b2b_3p4.sum_const", 32'(sum_par), 32'h7);
        checkVal("b2b_3p4.cout_const", 32'(cout), 32'h0);
        addWord("b2b_15p1", 15, 1);
        checkVal("b2b_15p1.sum_const", 32'(sum_par), 32'h0);
        checkVal("b2b_15p1.cout_const", 32'(cout), 32'h1);

        // Mid-word abort clears carry and count
        applyStimulus("abort_part", 0, 1, 1);
        applyStimulus("abort_part", 0, 1, 1);
        applyStimulus("abort_load", 1, 0, 0);
        addWord("abort_1p1", 1, 1);
        checkVal("abort_1p1.sum_const", 32'(sum_par), 32'h2);
        checkVal("abort_1p1.cout_const", 32'(cout), 32'h0);

        // Reset mid-word then a clean word
        applyStimulus("rstmid_part", 0, 1, 1);
        applyStimulus("rstmid_part", 0, 1, 0);
        pulseReset("rstmid");
        addWord("rstmid_9p9", 9, 9);
        checkVal("rstmid_9p9.sum_const", 32'(sum_par), 32'h2);
        checkVal("rstmid_9p9.cout_const", 32'(cout), 32'h1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            sel = int'($urandom_range(0, 99));
            if (sel < 2)
                pulseReset("rnd_rst");
            else if (sel < 15)
                applyStimulus("rnd_unload", 1, int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
            else
                applyStimulus("rnd_add", 0, int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", numChecks, numErrors);
        $finish;
    end

endmodule
